// File: rtl/usb_tx_scheduler.sv
// USB device transaction sequencer: maps host tokens/data to usb_tx
// requests, handles turnaround, data toggles and handshake tracking.
module usb_tx_scheduler #(
  parameter int TURNAROUND_CYCLES = 20,
  parameter int HS_TIMEOUT        = 150,
  parameter int CNT_W             = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rx_packet,
  input  logic       rx_packet_valid,
  input  logic       rx_error,
  input  logic       rx_buf_full,
  input  logic       ep_stall,
  input  logic [6:0] buffer_occupancy,
  input  logic       clear_toggle,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic [2:0] tx_packet,
  output logic       tx_commit,
  output logic       tx_retry,
  output logic       rx_discard,
  output logic       sched_error,
  output logic       busy
);

  localparam logic [2:0] PID_OUT   = 3'd0;
  localparam logic [2:0] PID_IN    = 3'd1;
  localparam logic [2:0] PID_DATA0 = 3'd2;
  localparam logic [2:0] PID_DATA1 = 3'd3;
  localparam logic [2:0] PID_ACK   = 3'd4;
  localparam logic [2:0] PID_NAK   = 3'd5;
  localparam logic [2:0] PID_STALL = 3'd6;
  localparam logic [2:0] PID_IDLE  = 3'd7;

  localparam logic [CNT_W-1:0] LP_TA_LAST =
    CNT_W'(TURNAROUND_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_HS_LAST =
    CNT_W'(HS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_DELAY,
    S_LAUNCH,
    S_SENDING,
    S_WAIT_HS
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic [2:0]       r_resp;
  logic [2:0]       w_resp;
  logic             r_rx_flip;
  logic             w_rx_flip;
  logic             r_tx_tog;
  logic             r_rx_tog;
  logic [2:0]       r_tx_packet;
  logic [2:0]       w_tx_packet;
  logic             r_commit;
  logic             r_retry;
  logic             r_discard;
  logic             r_serr;
  logic             w_commit;
  logic             w_retry;
  logic             w_discard;
  logic             w_serr;
  logic             w_tx_tog_flip;
  logic             w_rx_tog_flip;
  logic             w_rx_ok;
  logic             w_resp_data;
  logic             w_pid_data;

  assign w_rx_ok     = rx_packet_valid & ~rx_error;
  assign w_resp_data = (r_resp == PID_DATA0) |
                       (r_resp == PID_DATA1);
  assign w_pid_data  = (rx_packet == PID_DATA0) |
                       (rx_packet == PID_DATA1);

  always_comb begin
    w_next        = r_state;
    w_cnt         = r_cnt;
    w_resp        = r_resp;
    w_rx_flip     = r_rx_flip;
    w_commit      = 1'b0;
    w_retry       = 1'b0;
    w_discard     = 1'b0;
    w_serr        = 1'b0;
    w_tx_tog_flip = 1'b0;
    w_rx_tog_flip = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rx_ok && rx_packet == PID_IN) begin
          w_rx_flip = 1'b0;
          w_cnt     = '0;
          w_next    = S_DELAY;
          if (ep_stall) begin
            w_resp = PID_STALL;
          end else if (buffer_occupancy == 7'd0) begin
            w_resp = PID_NAK;
          end else begin
            w_resp = r_tx_tog ? PID_DATA1 : PID_DATA0;
          end
        end else if (w_rx_ok && rx_packet == PID_OUT) begin
          w_cnt  = '0;
          w_next = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (rx_packet_valid) begin
          if (w_rx_ok && w_pid_data) begin
            w_cnt     = '0;
            w_next    = S_DELAY;
            w_rx_flip = 1'b0;
            if (ep_stall) begin
              w_resp = PID_STALL;
            end else if (rx_buf_full) begin
              w_resp = PID_NAK;
            end else if (rx_packet[0] == r_rx_tog) begin
              w_resp    = PID_ACK;
              w_rx_flip = 1'b1;
            end else begin
              // duplicate of data we already ACKed: ACK again, drop it
              w_resp    = PID_ACK;
              w_discard = 1'b1;
            end
          end else begin
            w_next = S_IDLE;
          end
        end else if (r_cnt == LP_HS_LAST) begin
          w_next = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DELAY: begin
        if (r_cnt == LP_TA_LAST) begin
          w_next        = S_LAUNCH;
          w_rx_tog_flip = (r_resp == PID_ACK) & r_rx_flip;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_LAUNCH: begin
        if (tx_error) begin
          w_serr  = 1'b1;
          w_retry = w_resp_data;
          w_next  = S_IDLE;
        end else if (tx_transfer_active) begin
          w_next = S_SENDING;
        end
      end
      S_SENDING: begin
        if (tx_error) begin
          w_serr  = 1'b1;
          w_retry = w_resp_data;
          w_next  = S_IDLE;
        end else if (!tx_transfer_active) begin
          w_cnt  = '0;
          w_next = w_resp_data ? S_WAIT_HS : S_IDLE;
        end
      end
      S_WAIT_HS: begin
        if (rx_packet_valid) begin
          w_next = S_IDLE;
          if (w_rx_ok && rx_packet == PID_ACK) begin
            w_commit      = 1'b1;
            w_tx_tog_flip = 1'b1;
          end else begin
            w_retry = 1'b1;
          end
        end else if (r_cnt == LP_HS_LAST) begin
          w_retry = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_tx_packet =
    (w_next == S_LAUNCH || w_next == S_SENDING) ?
    w_resp : PID_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_resp      <= PID_IDLE;
      r_rx_flip   <= 1'b0;
      r_tx_tog    <= 1'b0;
      r_rx_tog    <= 1'b0;
      r_tx_packet <= PID_IDLE;
      r_commit    <= 1'b0;
      r_retry     <= 1'b0;
      r_discard   <= 1'b0;
      r_serr      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_resp      <= w_resp;
      r_rx_flip   <= w_rx_flip;
      r_tx_packet <= w_tx_packet;
      r_commit    <= w_commit;
      r_retry     <= w_retry;
      r_discard   <= w_discard;
      r_serr      <= w_serr;
      // clear_toggle beats a same-cycle flip
      r_tx_tog    <= clear_toggle ? 1'b0 : (r_tx_tog ^ w_tx_tog_flip);
      r_rx_tog    <= clear_toggle ? 1'b0 : (r_rx_tog ^ w_rx_tog_flip);
    end
  end

  assign tx_packet   = r_tx_packet;
  assign tx_commit   = r_commit;
  assign tx_retry    = r_retry;
  assign rx_discard  = r_discard;
  assign sched_error = r_serr;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Randomized self-checking bench for usb_tx_scheduler against a
// transaction-level model of toggles and handshake outcomes.
`timescale 1ns/1ps
module tb_usb_tx_scheduler;

  localparam int TA = 20;
  localparam int HS = 150;
  localparam logic [2:0] P_OUT   = 3'd0;
  localparam logic [2:0] P_IN    = 3'd1;
  localparam logic [2:0] P_DATA0 = 3'd2;
  localparam logic [2:0] P_DATA1 = 3'd3;
  localparam logic [2:0] P_ACK   = 3'd4;
  localparam logic [2:0] P_NAK   = 3'd5;
  localparam logic [2:0] P_STALL = 3'd6;
  localparam logic [2:0] P_IDLE  = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_packet;
  logic       rx_packet_valid;
  logic       rx_error;
  logic       rx_buf_full;
  logic       ep_stall;
  logic [6:0] buffer_occupancy;
  logic       clear_toggle;
  logic       tx_transfer_active;
  logic       tx_error;
  logic [2:0] tx_packet;
  logic       tx_commit;
  logic       tx_retry;
  logic       rx_discard;
  logic       sched_error;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int n_commit = 0;
  int n_retry = 0;
  int n_discard = 0;
  int n_serr = 0;
  int n_wide = 0;
  logic p_c = 0, p_r = 0, p_d = 0, p_s = 0;

  bit m_tx_tog;
  bit m_rx_tog;

  always #5 clk = ~clk;

  usb_tx_scheduler #(
    .TURNAROUND_CYCLES(TA),
    .HS_TIMEOUT(HS),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_packet(rx_packet),
    .rx_packet_valid(rx_packet_valid),
    .rx_error(rx_error),
    .rx_buf_full(rx_buf_full),
    .ep_stall(ep_stall),
    .buffer_occupancy(buffer_occupancy),
    .clear_toggle(clear_toggle),
    .tx_transfer_active(tx_transfer_active),
    .tx_error(tx_error),
    .tx_packet(tx_packet),
    .tx_commit(tx_commit),
    .tx_retry(tx_retry),
    .rx_discard(rx_discard),
    .sched_error(sched_error),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (tx_commit === 1'b1) n_commit++;
    if (tx_retry === 1'b1) n_retry++;
    if (rx_discard === 1'b1) n_discard++;
    if (sched_error === 1'b1) n_serr++;
    if ((tx_commit && p_c) || (tx_retry && p_r) ||
        (rx_discard && p_d) || (sched_error && p_s))
      n_wide++;
    p_c = tx_commit;
    p_r = tx_retry;
    p_d = rx_discard;
    p_s = sched_error;
  end

  task automatic send_pkt(input logic [2:0] pid,
                          input logic err,
                          input logic clr);
    @(posedge clk); #1;
    rx_packet       = pid;
    rx_error        = err;
    clear_toggle    = clr;
    rx_packet_valid = 1'b1;
    @(posedge clk); #1;
    rx_packet_valid = 1'b0;
    rx_error        = 1'b0;
    clear_toggle    = 1'b0;
    rx_packet       = 3'($urandom);
  endtask

  task automatic wait_req(output int k);
    k = 0;
    @(negedge clk);
    while (tx_packet === P_IDLE && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic tx_run(input logic [2:0] exp, input int len);
    @(posedge clk); #1;
    tx_transfer_active = 1'b1;
    repeat (len) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_packet !== exp) begin
      failures++;
      $display("FAIL tx_hold got=%0d exp=%0d", tx_packet, exp);
    end
    @(posedge clk); #1;
    tx_transfer_active = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_packet !== P_IDLE) begin
      failures++;
      $display("FAIL tx_release got=%0d exp=7", tx_packet);
    end
  endtask

  // hs: 0 ACK after 40 clks, 1 NAK, 2 errored ACK, 3 no handshake
  task automatic do_in(input bit stall, input logic [6:0] occ,
                       input int hs);
    logic [2:0] exp;
    int k, c0, r0, ec, er;
    bit is_data;
    @(posedge clk); #1;
    c0 = n_commit;
    r0 = n_retry;
    if (stall) exp = P_STALL;
    else if (occ == 0) exp = P_NAK;
    else exp = m_tx_tog ? P_DATA1 : P_DATA0;
    is_data = (exp == P_DATA0) || (exp == P_DATA1);
    ec = (is_data && hs == 0) ? 1 : 0;
    er = (is_data && hs != 0) ? 1 : 0;
    ep_stall = stall;
    buffer_occupancy = occ;
    send_pkt(P_IN, 1'b0, 1'b0);
    ep_stall = 1'($urandom);
    buffer_occupancy = 7'($urandom);
    wait_req(k);
    checks++;
    if (k != TA) begin
      failures++;
      $display("FAIL in_latency got=%0d exp=%0d", k, TA);
    end
    checks++;
    if (tx_packet !== exp) begin
      failures++;
      $display("FAIL in_resp got=%0d exp=%0d", tx_packet, exp);
    end
    tx_run(exp, $urandom_range(2, 12));
    if (is_data) begin
      case (hs)
        0: begin
          repeat (38) @(posedge clk);
          send_pkt(P_ACK, 1'b0, 1'b0);
          @(negedge clk);
          checks++;
          if (tx_commit !== 1'b1) begin
            failures++;
            $display("FAIL ack_commit got=%0d exp=1", tx_commit);
          end
          m_tx_tog = ~m_tx_tog;
        end
        1: send_pkt(P_NAK, 1'b0, 1'b0);
        2: send_pkt(P_ACK, 1'b1, 1'b0);
        default: begin
          k = 0;
          while (tx_retry !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
          end
          checks++;
          if (k != HS) begin
            failures++;
            $display("FAIL hs_timeout got=%0d exp=%0d", k, HS);
          end
        end
      endcase
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL in_idle got=%0d exp=0", busy);
    end
    checks++;
    if (n_commit - c0 != ec || n_retry - r0 != er) begin
      failures++;
      $display("FAIL in_pulses got=%0d/%0d exp=%0d/%0d",
               n_commit - c0, n_retry - r0, ec, er);
    end
  endtask

  task automatic do_out(input bit stall, input bit full,
                        input bit pid1, input bit err);
    logic [2:0] exp;
    int k, d0, c0, r0, ed;
    bit match;
    @(posedge clk); #1;
    d0 = n_discard;
    c0 = n_commit;
    r0 = n_retry;
    match = (pid1 == m_rx_tog);
    if (stall) exp = P_STALL;
    else if (full) exp = P_NAK;
    else exp = P_ACK;
    ed = (!err && !stall && !full && !match) ? 1 : 0;
    send_pkt(P_OUT, 1'b0, 1'b0);
    repeat ($urandom_range(1, 15)) @(posedge clk);
    #1;
    ep_stall = stall;
    rx_buf_full = full;
    send_pkt(pid1 ? P_DATA1 : P_DATA0, err, 1'b0);
    ep_stall = 1'($urandom);
    rx_buf_full = 1'($urandom);
    if (err) begin
      repeat (TA + 5) @(negedge clk);
      checks++;
      if (tx_packet !== P_IDLE || busy !== 1'b0) begin
        failures++;
        $display("FAIL out_err_silent got=%0d/%0d exp=7/0",
                 tx_packet, busy);
      end
    end else begin
      wait_req(k);
      checks++;
      if (k != TA) begin
        failures++;
        $display("FAIL out_latency got=%0d exp=%0d", k, TA);
      end
      checks++;
      if (tx_packet !== exp) begin
        failures++;
        $display("FAIL out_resp got=%0d exp=%0d", tx_packet, exp);
      end
      tx_run(exp, $urandom_range(2, 6));
      if (!stall && !full && match) m_rx_tog = ~m_rx_tog;
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || n_discard - d0 != ed ||
        n_commit != c0 || n_retry != r0) begin
      failures++;
      $display("FAIL out_pulses busy=%0d disc=%0d exp_disc=%0d cr=%0d/%0d",
               busy, n_discard - d0, ed, n_commit - c0, n_retry - r0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_packet = 3'd0;
    rx_packet_valid = 1'b0;
    rx_error = 1'b0;
    rx_buf_full = 1'b0;
    ep_stall = 1'b0;
    buffer_occupancy = 7'd0;
    clear_toggle = 1'b0;
    tx_transfer_active = 1'b0;
    tx_error = 1'b0;
    m_tx_tog = 1'b0;
    m_rx_tog = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_packet !== P_IDLE || busy !== 1'b0 || tx_commit !== 1'b0 ||
        tx_retry !== 1'b0 || rx_discard !== 1'b0 ||
        sched_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d exp=7/0", tx_packet, busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_in_basic();
    do_in(1'b0, 7'd3, 0);
    do_in(1'b0, 7'd5, 0);
  endtask

  task automatic test_nak_stall();
    do_in(1'b0, 7'd0, 0);
    do_in(1'b1, 7'd5, 0);
  endtask

  task automatic test_timeout();
    do_in(1'b0, 7'd9, 3);
    do_in(1'b0, 7'd9, 0);
  endtask

  task automatic test_out();
    do_out(1'b0, 1'b0, m_rx_tog, 1'b0);
    do_out(1'b0, 1'b0, ~m_rx_tog, 1'b0);
    do_out(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_tx_error();
    int k, s0, r0, c0;
    if (!m_tx_tog) do_in(1'b0, 7'd4, 0);
    @(posedge clk); #1;
    s0 = n_serr;
    r0 = n_retry;
    c0 = n_commit;
    ep_stall = 1'b0;
    buffer_occupancy = 7'd7;
    send_pkt(P_IN, 1'b0, 1'b0);
    wait_req(k);
    checks++;
    if (tx_packet !== P_DATA1) begin
      failures++;
      $display("FAIL txerr_resp got=%0d exp=%0d", tx_packet, P_DATA1);
    end
    @(posedge clk); #1;
    tx_transfer_active = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_error = 1'b1;
    @(posedge clk); #1;
    tx_error = 1'b0;
    tx_transfer_active = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_packet !== P_IDLE || busy !== 1'b0 ||
        sched_error !== 1'b1 || tx_retry !== 1'b1) begin
      failures++;
      $display("FAIL txerr_next got=%0d/%0d/%0d/%0d exp=7/0/1/1",
               tx_packet, busy, sched_error, tx_retry);
    end
    @(negedge clk); #1;
    checks++;
    if (n_serr - s0 != 1 || n_retry - r0 != 1 || n_commit != c0) begin
      failures++;
      $display("FAIL txerr_pulses got=%0d/%0d/%0d exp=1/1/0",
               n_serr - s0, n_retry - r0, n_commit - c0);
    end
    do_in(1'b0, 7'd2, 0);
  endtask

  task automatic test_reset_mid();
    int k, c0, r0;
    logic [2:0] exp;
    @(posedge clk); #1;
    ep_stall = 1'b0;
    buffer_occupancy = 7'd6;
    exp = m_tx_tog ? P_DATA1 : P_DATA0;
    send_pkt(P_IN, 1'b0, 1'b0);
    wait_req(k);
    tx_run(exp, 4);
    repeat (10) @(negedge clk);
    #2;
    c0 = n_commit;
    r0 = n_retry;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_packet !== P_IDLE || busy !== 1'b0 || tx_commit !== 1'b0 ||
        tx_retry !== 1'b0 || sched_error !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got=%0d/%0d exp=7/0", tx_packet, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_tx_tog = 1'b0;
    m_rx_tog = 1'b0;
    repeat (HS + 10) @(negedge clk);
    #1;
    checks++;
    if (n_commit != c0 || n_retry != r0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_pulse got=%0d/%0d exp=0/0",
               n_commit - c0, n_retry - r0);
    end
    do_in(1'b0, 7'd1, 0);
  endtask

  task automatic test_clear_toggle();
    int k;
    logic [2:0] exp;
    if (!m_rx_tog) do_out(1'b0, 1'b0, 1'b0, 1'b0);
    if (m_tx_tog) do_in(1'b0, 7'd3, 0);
    @(posedge clk); #1;
    ep_stall = 1'b0;
    buffer_occupancy = 7'd8;
    exp = P_DATA0;
    send_pkt(P_IN, 1'b0, 1'b0);
    wait_req(k);
    tx_run(exp, 3);
    repeat (38) @(posedge clk);
    send_pkt(P_ACK, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (tx_commit !== 1'b1) begin
      failures++;
      $display("FAIL clr_commit got=%0d exp=1", tx_commit);
    end
    m_tx_tog = 1'b0;
    m_rx_tog = 1'b0;
    do_in(1'b0, 7'd2, 0);
    do_out(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        @(posedge clk); #1;
        clear_toggle = 1'b1;
        @(posedge clk); #1;
        clear_toggle = 1'b0;
        m_tx_tog = 1'b0;
        m_rx_tog = 1'b0;
      end else if (r < 6) begin
        do_in($urandom_range(0, 7) == 0,
              ($urandom_range(0, 5) == 0) ? 7'd0 :
              7'($urandom_range(1, 127)),
              $urandom_range(0, 3));
      end else begin
        do_out($urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0,
               1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_basic();
    test_nak_stall();
    test_timeout();
    test_out();
    test_tx_error();
    test_reset_mid();
    test_clear_toggle();
    test_random();
    @(negedge clk); #1;
    checks++;
    if (n_wide != 0) begin
      failures++;
      $display("FAIL pulse_width got=%0d exp=0", n_wide);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
